// File: rtl/fc_neuron_mac.sv
// Time-multiplexed fully-connected neuron: accumulates LANES signed products per beat over
// IN/LANES beats, then returns act(sum) through a valid/ready result port.
module fc_neuron_mac #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IN      = 128,
  parameter int unsigned LANES   = 8,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [LANES*WIDTH-1:0]           s_x,
  input  logic [LANES*WIDTH-1:0]           s_w,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [2*WIDTH+$clog2(IN)-1:0]    m_data
);

  localparam int unsigned BEATS  = IN / LANES;
  localparam int unsigned OUT_W  = 2 * WIDTH + $clog2(IN);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  if (IN % LANES != 0) begin : g_bad_cfg
    $error("fc_neuron_mac: IN must be a multiple of LANES");
  end

  typedef enum logic [1:0] {StAcc, StDrain, StOut} state_e;

  state_e state_q, state_d;

  logic                     s_ready_q, s_ready_d;
  logic                     m_valid_q, m_valid_d;
  logic signed [OUT_W-1:0]  m_data_q, m_data_d;

  logic [BEAT_W-1:0]        beat_q;
  logic signed [OUT_W-1:0]  psum_q;
  logic                     pv_q, pfirst_q, plast_q;
  logic signed [OUT_W-1:0]  acc_q;

  logic                     s_fire;
  logic                     last_beat;
  logic signed [OUT_W-1:0]  lane_sum;
  logic signed [OUT_W-1:0]  acc_sum;
  logic signed [OUT_W-1:0]  act_val;
  logic                     load_result;

  assign s_fire    = s_valid && s_ready_q;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    logic signed [WIDTH-1:0]  xk;
    logic signed [WIDTH-1:0]  wk;
    logic signed [PROD_W-1:0] prod;
    xk       = '0;
    wk       = '0;
    prod     = '0;
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      xk       = s_x[k*WIDTH +: WIDTH];
      wk       = s_w[k*WIDTH +: WIDTH];
      prod     = PROD_W'(xk) * PROD_W'(wk);
      lane_sum = lane_sum + OUT_W'(prod);
    end
  end

  // Stage 1: register the lane sum with its position flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q   <= '0;
      psum_q   <= '0;
      pv_q     <= 1'b0;
      pfirst_q <= 1'b0;
      plast_q  <= 1'b0;
    end else begin
      pv_q <= s_fire;
      if (s_fire) begin
        psum_q   <= lane_sum;
        pfirst_q <= (beat_q == '0);
        plast_q  <= last_beat;
        beat_q   <= last_beat ? '0 : beat_q + BEAT_W'(1);
      end
    end
  end

  // Stage 2: the first beat overwrites, so no clear cycle between vectors.
  assign acc_sum = pfirst_q ? psum_q : acc_q + psum_q;
  assign act_val = (RELU_EN && acc_sum[OUT_W-1]) ? '0 : acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (pv_q) begin
      acc_q <= acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAcc;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (s_fire && last_beat) state_d = StDrain;
      StDrain: state_d = StOut;
      StOut:   if (m_ready) state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  // Handshake outputs are registered from the next state so they never glitch.
  always_comb begin
    load_result = (state_q == StDrain) && pv_q && plast_q;
    s_ready_d   = (state_d == StAcc);
    m_valid_d   = (state_d == StOut);
    m_data_d    = load_result ? act_val : m_data_q;
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Directed bench for fc_neuron_mac: a 128/8 pair and a 12/4 pair (ReLU and linear each),
// checked every cycle against a dot-product/timing model plus hand-computed literals.
module tb_fc_neuron_mac;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        va = 1'b0, ma = 1'b1;
  logic [63:0] xa = '0, wa = '0;
  logic        rdy_a0, rdy_a1, mv_a0, mv_a1;
  logic [22:0] d_a0, d_a1;

  logic        vc = 1'b0, mc = 1'b1;
  logic [31:0] xc = '0, wc = '0;
  logic        rdy_c0, rdy_c1, mv_c0, mv_c1;
  logic [19:0] d_c0, d_c1;

  int nvec = 0;
  int nerr = 0;

  fc_neuron_mac #(.WIDTH(8), .IN(128), .LANES(8), .RELU_EN(1'b1)) u_a0 (
    .clk(clk), .rst_n(rst_n), .s_valid(va), .s_ready(rdy_a0), .s_x(xa), .s_w(wa),
    .m_valid(mv_a0), .m_ready(ma), .m_data(d_a0));
  fc_neuron_mac #(.WIDTH(8), .IN(128), .LANES(8), .RELU_EN(1'b0)) u_a1 (
    .clk(clk), .rst_n(rst_n), .s_valid(va), .s_ready(rdy_a1), .s_x(xa), .s_w(wa),
    .m_valid(mv_a1), .m_ready(ma), .m_data(d_a1));
  fc_neuron_mac #(.WIDTH(8), .IN(12), .LANES(4), .RELU_EN(1'b1)) u_c0 (
    .clk(clk), .rst_n(rst_n), .s_valid(vc), .s_ready(rdy_c0), .s_x(xc), .s_w(wc),
    .m_valid(mv_c0), .m_ready(mc), .m_data(d_c0));
  fc_neuron_mac #(.WIDTH(8), .IN(12), .LANES(4), .RELU_EN(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .s_valid(vc), .s_ready(rdy_c1), .s_x(xc), .s_w(wc),
    .m_valid(mv_c1), .m_ready(mc), .m_data(d_c1));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Model: pair 0 = IN 128 / LANES 8, pair 1 = IN 12 / LANES 4.
  bit     rdy_m [2];
  int     age_m [2];  // edges since the last beat of a vector was taken; -1 when idle
  int     cnt_m [2];
  longint sum_m [2];
  longint res_m [2];

  function automatic int beats(int p);
    return (p == 0) ? 16 : 3;
  endfunction

  function automatic longint dot(logic [63:0] x, logic [63:0] w, int lanes);
    longint s = 0;
    for (int k = 0; k < lanes; k++)
      s += longint'($signed(x[k*8 +: 8])) * longint'($signed(w[k*8 +: 8]));
    return s;
  endfunction

  function automatic longint dotp(int p);
    return (p == 0) ? dot(xa, wa, 8) : dot({32'b0, xc}, {32'b0, wc}, 4);
  endfunction

  function automatic longint exp_data(int p, bit relu);
    return (relu && res_m[p] < 0) ? 64'sd0 : res_m[p];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        rdy_m[p] <= 1'b0;
        age_m[p] <= -1;
        cnt_m[p] <= 0;
        sum_m[p] <= 0;
        res_m[p] <= 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (((p == 0) ? va : vc) && rdy_m[p]) begin
          if (cnt_m[p] == beats(p) - 1) begin
            res_m[p] <= sum_m[p] + dotp(p);
            sum_m[p] <= 0;
            cnt_m[p] <= 0;
            age_m[p] <= 0;
            rdy_m[p] <= 1'b0;
          end else begin
            sum_m[p] <= sum_m[p] + dotp(p);
            cnt_m[p] <= cnt_m[p] + 1;
            rdy_m[p] <= 1'b1;
          end
        end else if (age_m[p] >= 1 && ((p == 0) ? ma : mc)) begin
          age_m[p] <= -1;
          rdy_m[p] <= 1'b1;
        end else if (age_m[p] >= 0) begin
          age_m[p] <= age_m[p] + 1;
          rdy_m[p] <= 1'b0;
        end else begin
          rdy_m[p] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a0_s_ready", {63'b0, rdy_a0}, {63'b0, rdy_m[0]});
    chk("a1_s_ready", {63'b0, rdy_a1}, {63'b0, rdy_m[0]});
    chk("c0_s_ready", {63'b0, rdy_c0}, {63'b0, rdy_m[1]});
    chk("c1_s_ready", {63'b0, rdy_c1}, {63'b0, rdy_m[1]});
    chk("a0_m_valid", {63'b0, mv_a0}, {63'b0, age_m[0] >= 1});
    chk("a1_m_valid", {63'b0, mv_a1}, {63'b0, age_m[0] >= 1});
    chk("c0_m_valid", {63'b0, mv_c0}, {63'b0, age_m[1] >= 1});
    chk("c1_m_valid", {63'b0, mv_c1}, {63'b0, age_m[1] >= 1});
    if (!rst_n || age_m[0] >= 1) begin
      chk("a0_m_data", 64'($signed(d_a0)), !rst_n ? 64'd0 : exp_data(0, 1'b1));
      chk("a1_m_data", 64'($signed(d_a1)), !rst_n ? 64'd0 : exp_data(0, 1'b0));
    end
    if (!rst_n || age_m[1] >= 1) begin
      chk("c0_m_data", 64'($signed(d_c0)), !rst_n ? 64'd0 : exp_data(1, 1'b1));
      chk("c1_m_data", 64'($signed(d_c1)), !rst_n ? 64'd0 : exp_data(1, 1'b0));
    end
  end

  // Send nb beats to pair p; mode 1 = ramp x[i]=i-64, w=wv; bub = bubble percentage.
  task automatic send(int p, int nb, int mode, int xv, int wv, int bub);
    int          lanes = (p == 0) ? 8 : 4;
    logic [63:0] x, w;
    logic        r, v;
    int          tries;
    bit          done;
    for (int b = 0; b < nb; b++) begin
      x = '0;
      w = '0;
      for (int k = 0; k < lanes; k++) begin
        x[k*8 +: 8] = 8'((mode == 1) ? (b * lanes + k - 64) : xv);
        w[k*8 +: 8] = 8'(wv);
      end
      if (p == 0) begin xa = x; wa = w; end
      else begin xc = x[31:0]; wc = w[31:0]; end
      done  = 1'b0;
      tries = 0;
      while (!done) begin
        v = ($urandom_range(0, 99) >= bub);
        if (p == 0) begin va = v; r = rdy_a0; end
        else begin vc = v; r = rdy_c0; end
        @(posedge clk);
        #1;
        done = v && r;
        tries++;
        if (!done && tries > 200) begin
          chk("beat_accept_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
    va = 1'b0;
    vc = 1'b0;
  endtask

  // Wait for the result of pair p and pin it to literal values; n = negedges sampled.
  task automatic wait_res(int p, string name, longint e_relu, longint e_lin, output int n);
    logic mv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      mv = (p == 0) ? mv_a0 : mv_c0;
    end while (!mv && n < 50);
    chk({name, "_valid"}, {63'b0, mv}, 64'd1);
    if (p == 0) begin
      chk({name, "_relu"}, 64'($signed(d_a0)), e_relu);
      chk({name, "_lin"},  64'($signed(d_a1)), e_lin);
    end else begin
      chk({name, "_relu"}, 64'($signed(d_c0)), e_relu);
      chk({name, "_lin"},  64'($signed(d_c1)), e_lin);
    end
    chk({name, "_model"}, res_m[p], e_lin);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", {63'b0, rdy_a0}, 64'd0);
    chk("rst_m_valid", {63'b0, mv_a0}, 64'd0);
    chk("rst_m_data", 64'(d_a0), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All ones: 128, result two edges after the last beat.
    send(0, 16, 0, 1, 1, 0);
    wait_res(0, "t1", 128, 128, n);
    chk("t1_latency", 64'(n), 64'd2);
    @(posedge clk); #1;

    send(0, 16, 0, -128, -128, 0);
    wait_res(0, "t2_neg_neg", 2097152, 2097152, n);
    @(posedge clk); #1;
    send(0, 16, 0, -128, 127, 0);
    wait_res(0, "t2_neg_pos", 0, -2080768, n);
    @(posedge clk); #1;

    send(0, 16, 1, 0, 1, 0);
    wait_res(0, "t3_ramp", 0, -64, n);
    @(posedge clk); #1;
    send(0, 16, 1, 0, 1, 40);
    wait_res(0, "t3_ramp_bubbles", 0, -64, n);
    @(posedge clk); #1;

    // Backpressure: result must hold while m_ready is low.
    ma = 1'b0;
    send(0, 16, 0, 1, 1, 0);
    wait_res(0, "t4_held", 128, 128, n);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", {63'b0, mv_a0}, 64'd1);
      chk("t4_hold_data", 64'($signed(d_a0)), 64'd128);
      chk("t4_hold_ready", {63'b0, rdy_a0}, 64'd0);
    end
    ma = 1'b1;
    @(negedge clk);
    chk("t4_ready_after", {63'b0, rdy_a0}, 64'd1);
    send(0, 16, 0, 2, 3, 0);
    wait_res(0, "t4_second", 768, 768, n);
    @(posedge clk); #1;

    // Reset mid-vector discards the partial sum.
    send(0, 7, 0, 5, 5, 0);
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_rst_ready", {63'b0, rdy_a0}, 64'd0);
      chk("t5_rst_valid", {63'b0, mv_a0}, 64'd0);
      chk("t5_rst_data", 64'(d_a1), 64'd0);
    end
    #2 rst_n = 1'b1;
    send(0, 16, 0, 1, 1, 0);
    wait_res(0, "t5_after", 128, 128, n);
    @(posedge clk); #1;

    // IN=12, LANES=4.
    send(1, 3, 0, 7, -3, 0);
    wait_res(1, "t6_small", 0, -252, n);
    chk("t6_latency", 64'(n), 64'd2);
    @(posedge clk); #1;
    send(1, 3, 0, -128, -128, 30);
    wait_res(1, "t6_small_ext", 196608, 196608, n);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
